can_crc15_gen: RTL and testbench
================================

Name: can_crc15_gen

Overview:
- Downstream consumer of the one-cycle crc_en pulse produced from tx_start.
- Computes the CAN 2.0 CRC-15 over the serialized frame bits (SOF through end of data field), delivered one bit per bit_valid strobe.
- Holds the 15-bit result for the frame assembler.
- Shifts the result out MSB-first on demand into the CRC field of the transmit bitstream.

Parameters:
- POLY, 15'h4599, CAN CRC-15 generator polynomial (x^15+x^14+x^10+x^8+x^7+x^4+x^3+1).
- MAX_BITS, 83, largest legal frame length in bits (19 header bits + 64 data bits).
- LEN_W, 7, width of the bit-count input and the internal counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- crc_en  in  1  one-cycle start pulse from the oneshot stage; clears the CRC and latches len.
- len  in  LEN_W  number of frame bits to absorb; sampled only when crc_en=1.
- bit_in  in  1  serialized frame bit.
- bit_valid  in  1  bit_in is consumed this cycle (only in CALC).
- crc_shift  in  1  request the next CRC bit on crc_bit_out (only in DONE/SHIFT).
- busy  out  1  high in CALC.
- crc_valid  out  1  high in DONE and SHIFT; crc is final.
- crc  out  15  CRC register contents.
- crc_bit_out  out  1  current CRC output bit; registered.
- crc_bit_valid  out  1  one-cycle strobe qualifying crc_bit_out.
- len_err  out  1  one-cycle pulse when crc_en arrives with len > MAX_BITS.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - crc = 0, counter = 0.
  - busy, crc_valid, crc_bit_out, crc_bit_valid and len_err all = 0.
  - Reset takes effect the same way mid-frame and mid-shift.
- States: IDLE, CALC, DONE, SHIFT.
- crc_en = 1, any state:
  - crc <= 0.
  - If 1 <= len <= MAX_BITS: counter <= len, go to CALC.
  - If len = 0: go straight to DONE with crc = 0.
  - If len > MAX_BITS: len_err pulses next cycle, go to IDLE, crc <= 0.
  - crc_en has priority over bit_valid and crc_shift in the same cycle; that bit or shift is dropped.
- CALC, bit_valid = 1:
  - nxt = bit_in ^ crc[14].
  - crc <= {crc[13:0],1'b0} ^ (nxt ? POLY : 0).
  - counter decrements.
  - When the absorbed bit takes counter from 1 to 0, go to DONE.
  - crc_valid rises on the cycle after the last bit's edge (latency 1 from the last bit_valid).
- CALC, bit_valid = 0: hold crc and counter. There is no timeout.
- DONE: crc is stable and crc_valid = 1. bit_valid is ignored. crc_shift = 1 moves to SHIFT and emits bit 14.
- SHIFT:
  - Each crc_shift emits the next lower bit, MSB first.
  - crc_bit_out and crc_bit_valid are registered, so they appear the cycle after the crc_shift edge.
  - After bit 0 is emitted, go to IDLE and clear crc_valid.
  - crc itself is not altered by shifting; an internal 4-bit shift index is used.
  - crc_shift outside DONE/SHIFT is ignored.
- crc_bit_valid is 0 in every cycle without an accepted shift. crc_bit_out holds its last value.
- busy = (state == CALC). crc_valid = (state == DONE || state == SHIFT).

Decomposition:
- Shared package can_pkg:
  - CRC15_POLY = 15'h4599.
  - CAN_MAX_CRC_BITS = 83.
  - CRC state enum {IDLE, CALC, DONE, SHIFT}, 2-bit encoding.
- Sub-module can_crc15_step: combinational single-bit CRC update (crc_in, bit) -> crc_out.
  - Reused later by the receive-side CRC checker.

Test Plan:
- Reset then crc_en with len=1, one bit 1 -> busy for 1 bit; next cycle crc_valid=1, crc=15'h4599.
- crc_en with len=2, bits 1,0 with idle gaps between bit_valid strobes -> crc=15'h4EAB; busy held through the gaps.
- crc_en with len=19, all bits 0 -> crc=15'h0000 and crc_valid after the 19th bit. Then 15 crc_shift pulses -> 15 crc_bit_valid strobes, all bits 0; state returns to IDLE and crc_valid falls after the last strobe.
- Continuing the len=1 case, 15 crc_shift pulses -> serial sequence 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1 (0x4599 MSB first), each bit one cycle after its request.
- Boundary cases:
  - crc_en with len=0 -> DONE immediately, crc=0.
  - crc_en with len=84 -> len_err pulses once; state stays IDLE and crc_valid stays 0.
- Abort and reset:
  - Start len=10, feed 5 bits, then crc_en with len=1 and bit_valid=1 in the same cycle -> that bit is dropped; one more 1 bit -> crc=15'h4599.
  - Assert rst in mid-SHIFT -> all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN constants and CRC state encoding.
// No logic; types and parameters only.
// Not applicable: no datapath or flow control.
package can_pkg;
    localparam logic [14:0] CRC15_POLY       = 15'h4599;
    localparam int          CAN_MAX_CRC_BITS = 83;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2,
        SHIFT = 2'd3
    } crc_state_t;
endpackage

// File: rtl/can_crc15_step.sv
// Single-bit CRC-15 update, shared by the transmit generator and receive checker.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module can_crc15_step
    import can_pkg::*;
#(
    parameter logic [14:0] POLY = CRC15_POLY
) (
    input  logic [14:0] crc_in,
    input  logic        bit_in,
    output logic [14:0] crc_out
);
    logic nxt;

    assign nxt     = bit_in ^ crc_in[14];
    assign crc_out = {crc_in[13:0], 1'b0} ^ (nxt ? POLY : 15'h0000);
endmodule

// File: rtl/can_crc15_gen.sv
// CAN CRC-15 over a serialized frame, then MSB-first serial readout of the result.
// Latency: crc_valid 1 cycle after the last bit; each CRC bit 1 cycle after its crc_shift.
// Backpressure: bit_valid may stall indefinitely in CALC; crc_shift paces the readout.
module can_crc15_gen
    import can_pkg::*;
#(
    parameter logic [14:0] POLY     = CRC15_POLY,
    parameter int          MAX_BITS = CAN_MAX_CRC_BITS,
    parameter int          LEN_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             crc_en,
    input  logic [LEN_W-1:0] len,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             crc_shift,
    output logic             busy,
    output logic             crc_valid,
    output logic [14:0]      crc,
    output logic             crc_bit_out,
    output logic             crc_bit_valid,
    output logic             len_err
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    crc_state_t       state, state_nxt;
    logic [14:0]      crc_q, crc_nxt, step_out;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [3:0]       idx, idx_nxt;
    logic             bit_q, bit_nxt;
    logic             bvld_q, bvld_nxt;
    logic             lerr_q, lerr_nxt;

    can_crc15_step #(.POLY(POLY)) u_step (
        .crc_in  (crc_q),
        .bit_in  (bit_in),
        .crc_out (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            crc_q  <= '0;
            cnt    <= '0;
            idx    <= '0;
            bit_q  <= 1'b0;
            bvld_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            crc_q  <= crc_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            bit_q  <= bit_nxt;
            bvld_q <= bvld_nxt;
            lerr_q <= lerr_nxt;
        end
    end

    // crc_en overrides everything else this cycle, so a coincident bit or shift is lost.
    always_comb begin
        state_nxt = state;
        crc_nxt   = crc_q;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        bit_nxt   = bit_q;
        bvld_nxt  = 1'b0;
        lerr_nxt  = 1'b0;
        if (crc_en) begin
            crc_nxt = '0;
            idx_nxt = 4'd14;
            if (len == '0) begin
                state_nxt = DONE;
            end else if (len > MAX_LEN) begin
                state_nxt = IDLE;
                lerr_nxt  = 1'b1;
            end else begin
                state_nxt = CALC;
                cnt_nxt   = len;
            end
        end else begin
            case (state)
                CALC: begin
                    if (bit_valid) begin
                        crc_nxt = step_out;
                        cnt_nxt = cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            state_nxt = DONE;
                            idx_nxt   = 4'd14;
                        end
                    end
                end
                DONE, SHIFT: begin
                    if (crc_shift) begin
                        bit_nxt  = crc_q[idx];
                        bvld_nxt = 1'b1;
                        if (idx == 4'd0) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = SHIFT;
                            idx_nxt   = idx - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state == CALC);
    assign crc_valid     = (state == DONE) || (state == SHIFT);
    assign crc           = crc_q;
    assign crc_bit_out   = bit_q;
    assign crc_bit_valid = bvld_q;
    assign len_err       = lerr_q;
endmodule

// File: tb/tb_can_crc15_gen.sv
module tb_can_crc15_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crc_en = 1'b0;
    logic [6:0]  len = '0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        crc_shift = 1'b0;
    logic        busy, crc_valid, crc_bit_out, crc_bit_valid, len_err;
    logic [14:0] crc;

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_crc_q[$];
    logic        exp_bit_q[$];
    int          exp_lerr_q[$];

    can_crc15_gen dut (
        .clk           (clk),
        .rst           (rst),
        .crc_en        (crc_en),
        .len           (len),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .crc_shift     (crc_shift),
        .busy          (busy),
        .crc_valid     (crc_valid),
        .crc           (crc),
        .crc_bit_out   (crc_bit_out),
        .crc_bit_valid (crc_bit_valid),
        .len_err       (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    logic prev_cv    = 1'b0;
    logic shift_pend = 1'b0;
    always @(negedge clk) begin
        if (crc_valid === 1'b1 && prev_cv !== 1'b1) begin
            if (exp_crc_q.size() == 0) chk("unexpected_crc_valid", 32'd1, 32'd0);
            else chk("crc_value", {17'd0, crc}, {17'd0, exp_crc_q.pop_front()});
        end
        if (crc_bit_valid === 1'b1 || shift_pend) begin
            chk("bit_latency", {31'd0, crc_bit_valid}, {31'd0, shift_pend});
            if (crc_bit_valid === 1'b1) begin
                if (exp_bit_q.size() == 0) chk("unexpected_crc_bit", 32'd1, 32'd0);
                else chk("crc_bit", {31'd0, crc_bit_out}, {31'd0, exp_bit_q.pop_front()});
            end
        end
        if (len_err === 1'b1) begin
            if (exp_lerr_q.size() == 0) chk("unexpected_len_err", 32'd1, 32'd0);
            else chk("len_err", 32'd1, exp_lerr_q.pop_front());
        end
        shift_pend = crc_shift && (crc_valid === 1'b1) && !crc_en && !rst;
        prev_cv    = (crc_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int l);
        crc_en = 1'b1;
        len    = 7'(l);
        tick();
        crc_en = 1'b0;
    endtask

    task automatic feed(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic shift_out(input logic [14:0] val, input int n);
        for (int i = 0; i < n; i++) exp_bit_q.push_back(val[14-i]);
        crc_shift = 1'b1;
        repeat (n) tick();
        crc_shift = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
        chk("rst_crc", {17'd0, crc}, 32'd0);
        chk("rst_outs", {29'd0, crc_bit_out, crc_bit_valid, len_err}, 32'd0);
        rst = 1'b0;
        tick();

        // len=1, single 1 bit yields the polynomial itself
        exp_crc_q.push_back(15'h4599);
        start(1);
        chk("len1_busy", {31'd0, busy}, 32'd1);
        feed(1'b1);
        chk("len1_busy_end", {31'd0, busy}, 32'd0);
        chk("len1_valid", {31'd0, crc_valid}, 32'd1);
        tick();
        shift_out(15'h4599, 15);
        chk("len1_valid_after_shift", {31'd0, crc_valid}, 32'd0);
        tick();
        chk("len1_bitvld_clear", {31'd0, crc_bit_valid}, 32'd0);

        // len=0 clears the held 0x4599 and goes straight to DONE
        exp_crc_q.push_back(15'h0000);
        start(0);
        chk("len0_valid", {31'd0, crc_valid}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);

        // len=2, bits 1,0 with gaps
        exp_crc_q.push_back(15'h4EAB);
        start(2);
        feed(1'b1);
        repeat (3) tick();
        chk("gap_busy", {31'd0, busy}, 32'd1);
        chk("gap_valid", {31'd0, crc_valid}, 32'd0);
        feed(1'b0);
        chk("len2_valid", {31'd0, crc_valid}, 32'd1);
        tick();

        // len=19 zeros, then shift out zeros
        exp_crc_q.push_back(15'h0000);
        start(19);
        for (int i = 0; i < 19; i++) begin
            chk("len19_busy", {31'd0, busy}, 32'd1);
            feed(1'b0);
        end
        chk("len19_valid", {31'd0, crc_valid}, 32'd1);
        shift_out(15'h0000, 15);
        chk("len19_valid_fall", {31'd0, crc_valid}, 32'd0);
        chk("len19_busy_idle", {31'd0, busy}, 32'd0);
        tick();

        // len=84 is one over the maximum
        exp_lerr_q.push_back(1);
        start(84);
        chk("len84_valid", {31'd0, crc_valid}, 32'd0);
        chk("len84_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("len84_single_pulse", {31'd0, len_err}, 32'd0);
        chk("len84_valid_hold", {31'd0, crc_valid}, 32'd0);

        // abort: restart mid-frame with a coincident bit that must be dropped
        exp_crc_q.push_back(15'h4599);
        start(10);
        for (int i = 0; i < 5; i++) feed(1'b1);
        crc_en = 1'b1; len = 7'd1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        crc_en = 1'b0; bit_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_crc_cleared", {17'd0, crc}, 32'd0);
        feed(1'b1);
        tick();

        // reset in the middle of SHIFT; last emitted bit is 1
        shift_out(15'h4599, 5);
        rst = 1'b1;
        tick();
        chk("midshift_busy", {31'd0, busy}, 32'd0);
        chk("midshift_valid", {31'd0, crc_valid}, 32'd0);
        chk("midshift_crc", {17'd0, crc}, 32'd0);
        chk("midshift_outs", {29'd0, crc_bit_out, crc_bit_valid, len_err}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        chk("crc_queue_drained", exp_crc_q.size(), 32'd0);
        chk("bit_queue_drained", exp_bit_q.size(), 32'd0);
        chk("lerr_queue_drained", exp_lerr_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
